// File: rtl/tone_sequencer_if.sv
// Control/table-write bundle between menu logic and the tone sequencer.
// The sequencer takes the slave side; the menu logic or bench drives the master side.
interface tone_sequencer_if #(
   parameter int DEPTH = 16
);
   localparam int IDX_W = $clog2(DEPTH);

   logic             WR_EN;
   logic [IDX_W-1:0] WR_ADDR;
   logic [31:0]      WR_DIV;
   logic [15:0]      WR_DUR;
   logic             START;
   logic             STOP;
   logic             LOOP;
   logic [31:0]      DIV_N;
   logic             TONE_EN;
   logic             BUSY;
   logic [IDX_W-1:0] IDX;
   logic             DONE;

   modport master (
      output WR_EN, WR_ADDR, WR_DIV, WR_DUR, START, STOP, LOOP,
      input  DIV_N, TONE_EN, BUSY, IDX, DONE
   );

   modport slave (
      input  WR_EN, WR_ADDR, WR_DIV, WR_DUR, START, STOP, LOOP,
      output DIV_N, TONE_EN, BUSY, IDX, DONE
   );
endinterface

// File: rtl/tone_sequencer.sv
// Steps through a (divider, duration) table and drives flexible_clock's n input
// plus a tone gate; durations are counted in prescaled ticks of CLOCK.
module tone_sequencer #(
   parameter int DEPTH    = 16,
   parameter int TICK_DIV = 100_000
) (
   input logic             CLOCK,
   input logic             RESET,
   tone_sequencer_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

   state_t           state;
   logic [31:0]      tbl_div [DEPTH];
   logic [15:0]      tbl_dur [DEPTH];
   logic [PSC_W-1:0] prescaler;
   logic [15:0]      remaining;
   logic [31:0]      div_n;
   logic             tone_en;
   logic             done;
   logic [IDX_W-1:0] idx;

   logic tick;
   logic last_tick;
   logic seq_end;

   // Table storage carries no reset; entries are undefined until written.
   always_ff @(posedge CLOCK) begin
      if (bus.WR_EN) begin
         tbl_div[bus.WR_ADDR] <= bus.WR_DIV;
         tbl_dur[bus.WR_ADDR] <= bus.WR_DUR;
      end
   end

   assign tick      = (prescaler == PSC_W'(TICK_DIV - 1));
   assign last_tick = tick && (remaining == 16'd1);
   // End of sequence: an end marker is loaded, or the last table slot runs out.
   assign seq_end   = ((state == LOAD) && (tbl_dur[idx] == 16'd0)) ||
                      ((state == PLAY) && last_tick && (idx == IDX_W'(DEPTH - 1)));

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state     <= IDLE;
         div_n     <= '0;
         tone_en   <= 1'b0;
         idx       <= '0;
         done      <= 1'b0;
         prescaler <= '0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         if ((state != IDLE) && bus.STOP) begin
            state   <= IDLE;
            div_n   <= '0;
            tone_en <= 1'b0;
            idx     <= '0;
         end else if (seq_end) begin
            idx <= '0;
            if (bus.LOOP) begin
               state <= LOAD;
            end else begin
               state   <= IDLE;
               done    <= 1'b1;
               div_n   <= '0;
               tone_en <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (bus.START && !bus.STOP) begin
                     state <= LOAD;
                     idx   <= '0;
                  end
               end
               LOAD: begin
                  div_n     <= tbl_div[idx];
                  tone_en   <= (tbl_div[idx] != 32'd0);
                  remaining <= tbl_dur[idx];
                  prescaler <= '0;
                  state     <= PLAY;
               end
               PLAY: begin
                  if (tick) begin
                     prescaler <= '0;
                     remaining <= remaining - 16'd1;
                     if (remaining == 16'd1) begin
                        idx   <= idx + IDX_W'(1);
                        state <= LOAD;
                     end
                  end else begin
                     prescaler <= prescaler + PSC_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.DIV_N   = div_n;
   assign bus.TONE_EN = tone_en;
   assign bus.BUSY    = (state != IDLE);
   assign bus.IDX     = idx;
   assign bus.DONE    = done;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: a cycle-count model of playback checked every
// cycle, plus hand-computed expectations for the documented scenarios.
module tb_tone_sequencer;
   localparam int DEPTH = 16;
   localparam int TICK  = 4;

   logic CLOCK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLOCK = ~CLOCK;

   tone_sequencer_if #(.DEPTH(DEPTH)) bus ();
   tone_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK)) dut (
      .CLOCK(CLOCK),
      .RESET(RESET),
      .bus  (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each entry occupies one load cycle then DUR*TICK playing cycles.
   logic [31:0] m_div [DEPTH];
   logic [15:0] m_dur [DEPTH];
   bit          m_busy = 0, m_load = 0, m_done = 0, m_ton = 0;
   int          m_idx = 0, m_left = 0;
   logic [31:0] m_divn = '0;

   task automatic m_finish();
      m_idx = 0;
      if (bus.LOOP) begin
         m_load = 1;
      end else begin
         m_busy = 0;
         m_done = 1;
         m_divn = '0;
         m_ton  = 0;
      end
   endtask

   always @(posedge CLOCK) begin
      if (RESET) begin
         m_busy = 0; m_load = 0; m_done = 0; m_ton = 0;
         m_idx  = 0; m_left = 0; m_divn = '0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (bus.START && !bus.STOP) begin
               m_busy = 1; m_load = 1; m_idx = 0;
            end
         end else if (bus.STOP) begin
            m_busy = 0; m_idx = 0; m_divn = '0; m_ton = 0;
         end else if (m_load) begin
            if (m_dur[m_idx] == 16'd0) m_finish();
            else begin
               m_divn = m_div[m_idx];
               m_ton  = (m_divn != 32'd0);
               m_left = int'(m_dur[m_idx]) * TICK;
               m_load = 0;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               if (m_idx == DEPTH - 1) m_finish();
               else begin
                  m_idx++;
                  m_load = 1;
               end
            end
         end
      end
      if (bus.WR_EN) begin
         m_div[bus.WR_ADDR] = bus.WR_DIV;
         m_dur[bus.WR_ADDR] = bus.WR_DUR;
      end
      #1;
      check("DIV_N",   bus.DIV_N,   m_divn);
      check("TONE_EN", bus.TONE_EN, m_ton);
      check("BUSY",    bus.BUSY,    m_busy);
      check("IDX",     bus.IDX,     m_idx);
      check("DONE",    bus.DONE,    m_done);
   end

   task automatic wr(input int a, input logic [31:0] d, input logic [15:0] u);
      bus.WR_EN   = 1'b1;
      bus.WR_ADDR = 4'(a);
      bus.WR_DIV  = d;
      bus.WR_DUR  = u;
      @(negedge CLOCK);
      bus.WR_EN   = 1'b0;
   endtask

   task automatic pulse(input bit st, input bit sp);
      bus.START = st;
      bus.STOP  = sp;
      @(negedge CLOCK);
      bus.START = 1'b0;
      bus.STOP  = 1'b0;
   endtask

   // Observe up to max cycles (at negedges) or until DONE, tallying output patterns.
   task automatic run_seq(input int max, output int busy_n, output int t0,
                          output int i1, output int n777, output int dn);
      busy_n = 0; t0 = 0; i1 = 0; n777 = 0; dn = 0;
      for (int i = 0; i < max; i++) begin
         if (bus.DONE) begin
            dn = 1;
            break;
         end
         if (bus.BUSY) busy_n++;
         if (bus.IDX == 4'd0 && bus.TONE_EN) t0++;
         if (bus.IDX == 4'd1 && !bus.TONE_EN && bus.BUSY) i1++;
         if (bus.DIV_N == 32'd777) n777++;
         @(negedge CLOCK);
      end
   endtask

   initial begin
      int b, t0, i1, n7, dn;
      bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_DIV = '0; bus.WR_DUR = '0;
      bus.START = 1'b0; bus.STOP = 1'b0; bus.LOOP = 1'b0;
      RESET = 1'b1;
      repeat (2) @(negedge CLOCK);
      check("reset DIV_N", bus.DIV_N, 0);
      check("reset BUSY",  bus.BUSY, 0);
      check("reset IDX",   bus.IDX, 0);
      check("reset DONE",  bus.DONE, 0);
      RESET = 1'b0;

      for (int i = 0; i < DEPTH; i++) wr(i, 32'd0, 16'd0);
      wr(0, 32'd1000, 16'd2);
      wr(1, 32'd0, 16'd1);
      wr(2, 32'd500, 16'd0);

      // Basic sequence: 1 + 8 + 1 + 4 + 1 busy cycles, then DONE.
      pulse(1, 0);
      run_seq(60, b, t0, i1, n7, dn);
      check("basic done",       dn, 1);
      check("basic busy cycles", b, 15);
      check("basic tone0 cycles", t0, 8);
      check("basic rest1 cycles", i1, 4);
      @(negedge CLOCK);
      check("basic idle DIV_N", bus.DIV_N, 0);

      // Looping never reports DONE; dropping LOOP ends after the current pass.
      bus.LOOP = 1'b1;
      pulse(1, 0);
      run_seq(40, b, t0, i1, n7, dn);
      check("loop no done",    dn, 0);
      check("loop busy cycles", b, 40);
      bus.LOOP = 1'b0;
      run_seq(40, b, t0, i1, n7, dn);
      check("loop exit done",  dn, 1);
      @(negedge CLOCK);

      // Full table walk: 16 entries of 5 cycles each, no wrap.
      for (int i = 0; i < DEPTH; i++) wr(i, 32'(100 + i), 16'd1);
      pulse(1, 0);
      run_seq(200, b, t0, i1, n7, dn);
      check("full done",       dn, 1);
      check("full busy cycles", b, 80);
      @(negedge CLOCK);

      // STOP mid-entry, STOP+START together, START while busy.
      wr(0, 32'd1000, 16'd3);
      pulse(1, 0);
      repeat (5) @(negedge CLOCK);
      pulse(0, 1);
      check("stop BUSY",  bus.BUSY, 0);
      check("stop DIV_N", bus.DIV_N, 0);
      check("stop DONE",  bus.DONE, 0);
      pulse(1, 1);
      check("stop+start idle BUSY", bus.BUSY, 0);
      pulse(1, 0);
      repeat (3) @(negedge CLOCK);
      pulse(1, 0);
      check("restart ignored IDX",   bus.IDX, 0);
      check("restart ignored DIV_N", bus.DIV_N, 1000);
      pulse(1, 1);
      check("stop+start busy BUSY", bus.BUSY, 0);
      @(negedge CLOCK);

      // Live rewrite of entry 1 while entry 0 plays.
      wr(0, 32'd1000, 16'd2);
      wr(1, 32'd0, 16'd1);
      wr(2, 32'd500, 16'd0);
      pulse(1, 0);
      repeat (3) @(negedge CLOCK);
      wr(1, 32'd777, 16'd1);
      run_seq(60, b, t0, i1, n7, dn);
      check("live done",      dn, 1);
      check("live 777 cycles", n7, 5);
      @(negedge CLOCK);

      // RESET during PLAY.
      pulse(1, 0);
      repeat (4) @(negedge CLOCK);
      RESET = 1'b1;
      @(negedge CLOCK);
      check("mid reset DIV_N",   bus.DIV_N, 0);
      check("mid reset TONE_EN", bus.TONE_EN, 0);
      check("mid reset BUSY",    bus.BUSY, 0);
      check("mid reset IDX",     bus.IDX, 0);
      RESET = 1'b0;
      repeat (2) @(negedge CLOCK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
